// File: rtl/vend_pkg.sv
// Shared types and helpers for the multi-product vending controller:
// coin codes, FSM state enum, coin values and greedy change selection.
package vend_pkg;

  localparam logic [1:0] COIN_5  = 2'b00;
  localparam logic [1:0] COIN_10 = 2'b01;
  localparam logic [1:0] COIN_20 = 2'b10;
  localparam logic [1:0] COIN_50 = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    CREDIT,
    VEND,
    CHANGE
  } state_e;

  function automatic logic [5:0] coin_value(input logic [1:0] code);
    logic [5:0] v;
    v = 6'd5;
    unique case (code)
      COIN_5:  v = 6'd5;
      COIN_10: v = 6'd10;
      COIN_20: v = 6'd20;
      COIN_50: v = 6'd50;
    endcase
    return v;
  endfunction

  // Largest coin not exceeding the amount; callers only ask with
  // a nonzero multiple of 5, so COIN_5 is the floor.
  function automatic logic [1:0] greedy_change(input logic [31:0] amt);
    logic [1:0] c;
    if (amt >= 32'd50)      c = COIN_50;
    else if (amt >= 32'd20) c = COIN_20;
    else if (amt >= 32'd10) c = COIN_10;
    else                    c = COIN_5;
    return c;
  endfunction

endpackage

// File: rtl/vend_stock_bank.sv
// Per-product stock counters with decrement-by-id and restock.
// Ports: clk/rst, dec_en_i+dec_id_i, restock_i, empty_o (stock==0).
module vend_stock_bank #(
  parameter int NUM_PRODUCTS = 4,
  parameter int STOCK_W      = 4,
  parameter int STOCK_INIT   = 8,
  parameter int ID_W         = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    dec_en_i,
  input  logic [ID_W-1:0]         dec_id_i,
  input  logic                    restock_i,
  output logic [NUM_PRODUCTS-1:0] empty_o
);

  localparam logic [STOCK_W-1:0] INIT_V = STOCK_W'(STOCK_INIT);

  logic [STOCK_W-1:0]      stock_q [NUM_PRODUCTS];
  logic [STOCK_W-1:0]      stock_d [NUM_PRODUCTS];
  logic [NUM_PRODUCTS-1:0] empty_q;
  logic [NUM_PRODUCTS-1:0] empty_d;

  always_comb begin
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      stock_d[i] = stock_q[i];
      if (restock_i) begin
        stock_d[i] = INIT_V;
      end else if (dec_en_i && dec_id_i == ID_W'(i)
                   && stock_q[i] != '0) begin
        stock_d[i] = stock_q[i] - STOCK_W'(1);
      end
      empty_d[i] = (stock_d[i] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PRODUCTS; i++) begin
        stock_q[i] <= INIT_V;
      end
      empty_q <= {NUM_PRODUCTS{STOCK_INIT == 0}};
    end else begin
      for (int i = 0; i < NUM_PRODUCTS; i++) begin
        stock_q[i] <= stock_d[i];
      end
      empty_q <= empty_d;
    end
  end

  assign empty_o = empty_q;

endmodule

// File: rtl/vend_ctrl_multi.sv
// Multi-product vending controller: credit, vend, greedy change, refund.
// Ports: coin/sel/cancel/restock in; credit, busy, product, change,
// coin_reject, sel_err pulses and per-product empty out. All registered.
module vend_ctrl_multi
  import vend_pkg::*;
#(
  parameter int NUM_PRODUCTS = 4,
  parameter int CREDIT_W     = 8,
  parameter logic [NUM_PRODUCTS*CREDIT_W-1:0] PRICES =
    {8'd30, 8'd15, 8'd10, 8'd5},
  parameter int MAX_CREDIT   = 100,
  parameter int STOCK_W      = 4,
  parameter int STOCK_INIT   = 8,
  localparam int ID_W =
    (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    coin_valid,
  input  logic [1:0]              coin_code,
  input  logic                    sel_valid,
  input  logic [ID_W-1:0]         sel_id,
  input  logic                    cancel,
  input  logic                    restock,
  output logic [CREDIT_W-1:0]     credit,
  output logic                    busy,
  output logic                    product_valid,
  output logic [ID_W-1:0]         product_id,
  output logic                    chg_valid,
  output logic [1:0]              chg_code,
  output logic                    coin_reject,
  output logic                    sel_err,
  output logic [NUM_PRODUCTS-1:0] empty
);

  localparam int CW1 = CREDIT_W + 1;

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                pv_q, pv_d;
  logic [ID_W-1:0]     pid_q, pid_d;
  logic                cv_q, cv_d;
  logic [1:0]          cc_q, cc_d;
  logic                rej_q, rej_d;
  logic                serr_q, serr_d;
  logic                busy_q;

  logic                    dec_en;
  logic                    restock_en;
  logic [NUM_PRODUCTS-1:0] empty_w;

  logic [CREDIT_W-1:0] price;
  logic                id_hit;
  logic                in_stock;
  logic                sel_ok;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_ok;
  logic [1:0]          chg;
  logic [CREDIT_W-1:0] chg_left;

  always_comb begin
    price    = '0;
    id_hit   = 1'b0;
    in_stock = 1'b0;
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      if (sel_id == ID_W'(i)) begin
        price    = PRICES[i*CREDIT_W +: CREDIT_W];
        id_hit   = 1'b1;
        in_stock = !empty_w[i];
      end
    end
  end

  assign sel_ok = id_hit && in_stock && (credit_q >= price);

  // One extra bit so the ceiling test cannot be fooled by wrap.
  assign coin_sum = {1'b0, credit_q} + CW1'(coin_value(coin_code));
  assign coin_ok  = coin_sum <= CW1'(MAX_CREDIT);

  assign chg      = greedy_change(32'(credit_q));
  assign chg_left = credit_q - CREDIT_W'(coin_value(chg));

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    pv_d       = 1'b0;
    pid_d      = pid_q;
    cv_d       = 1'b0;
    cc_d       = cc_q;
    rej_d      = 1'b0;
    serr_d     = 1'b0;
    dec_en     = 1'b0;
    restock_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        restock_en = restock;
        serr_d     = sel_valid;
        if (coin_valid) begin
          if (coin_ok) begin
            credit_d = coin_sum[CREDIT_W-1:0];
            state_d  = CREDIT;
          end else begin
            rej_d = 1'b1;
          end
        end
      end
      CREDIT: begin
        if (cancel) begin
          rej_d   = coin_valid;
          state_d = CHANGE;
        end else if (sel_valid && sel_ok) begin
          rej_d    = coin_valid;
          pv_d     = 1'b1;
          pid_d    = sel_id;
          credit_d = credit_q - price;
          dec_en   = 1'b1;
          state_d  = VEND;
        end else begin
          serr_d = sel_valid;
          if (coin_valid) begin
            if (coin_ok) credit_d = coin_sum[CREDIT_W-1:0];
            else         rej_d    = 1'b1;
          end
        end
      end
      // The dispense cycle already pays the first change coin so
      // change starts one cycle after product_valid.
      VEND: begin
        rej_d   = coin_valid;
        serr_d  = sel_valid;
        state_d = IDLE;
        if (credit_q != '0) begin
          cv_d     = 1'b1;
          cc_d     = chg;
          credit_d = chg_left;
          if (chg_left != '0) state_d = CHANGE;
        end
      end
      CHANGE: begin
        rej_d    = coin_valid;
        serr_d   = sel_valid;
        cv_d     = 1'b1;
        cc_d     = chg;
        credit_d = chg_left;
        if (chg_left == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      credit_q <= '0;
      pv_q     <= 1'b0;
      pid_q    <= '0;
      cv_q     <= 1'b0;
      cc_q     <= COIN_5;
      rej_q    <= 1'b0;
      serr_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      pv_q     <= pv_d;
      pid_q    <= pid_d;
      cv_q     <= cv_d;
      cc_q     <= cc_d;
      rej_q    <= rej_d;
      serr_q   <= serr_d;
      busy_q   <= (state_d == VEND) || (state_d == CHANGE);
    end
  end

  vend_stock_bank #(
    .NUM_PRODUCTS(NUM_PRODUCTS),
    .STOCK_W     (STOCK_W),
    .STOCK_INIT  (STOCK_INIT),
    .ID_W        (ID_W)
  ) u_stock (
    .clk      (clk),
    .rst      (rst),
    .dec_en_i (dec_en),
    .dec_id_i (sel_id),
    .restock_i(restock_en),
    .empty_o  (empty_w)
  );

  assign credit        = credit_q;
  assign busy          = busy_q;
  assign product_valid = pv_q;
  assign product_id    = pid_q;
  assign chg_valid     = cv_q;
  assign chg_code      = cc_q;
  assign coin_reject   = rej_q;
  assign sel_err       = serr_q;
  assign empty         = empty_w;

endmodule
